// File: rtl/ym6045c_z80_window_bridge.sv
// ym6045c_z80_window_bridge: Z80 $8000-$FFFF window onto the 68000 bus via a serially loaded bank register; optional DTACK timeout under YM6045C_DTACK_TIMEOUT_EN
module ym6045c_z80_window_bridge #(
  parameter int BANK_WIDTH = 9,
  parameter int MIN_AS_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     CLK,
  input  logic                     nRES,
  input  logic [15:0]              z80_a,
  input  logic                     z80_mreq_n,
  input  logic                     z80_rd_n,
  input  logic                     z80_wr_n,
  input  logic                     z80_d0,
  output logic                     z80_wait_n,
  output logic                     m68k_br_n,
  input  logic                     m68k_bg_n,
  input  logic                     m68k_dtack_n,
  output logic                     m68k_bgack_n,
  output logic                     m68k_as_n,
  output logic                     m68k_uds_n,
  output logic                     m68k_lds_n,
  output logic                     m68k_rw,
  output logic [BANK_WIDTH+13:0]   m68k_a,
  output logic                     m68k_addr_oe,
  output logic [BANK_WIDTH-1:0]    bank,
  output logic                     busy,
  output logic                     timeout
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACK, S_CYC, S_DTW, S_END, S_REL} state_t;
  state_t state, nxt;
  logic [3:0] cnt;
  logic [7:0] tcnt;
  logic wr_q, lane, det, bank_wr, tmo_nxt, own, strb;
  assign det = state == S_IDLE && !z80_mreq_n && z80_a[15] && (!z80_rd_n || !z80_wr_n);
  assign bank_wr = state == S_IDLE && !z80_mreq_n && z80_a[15:8] == 8'h60 && wr_q && !z80_wr_n;
  assign own = nxt inside {S_ACK, S_CYC, S_DTW, S_END};
  assign strb = nxt == S_DTW || (nxt == S_CYC && m68k_rw);
  // next-state: one 68000 cycle per Z80 access, held in REL until the Z80 drops MREQ
  always_comb begin
    nxt = state;
    tmo_nxt = 1'b0;
    case (state)
      S_IDLE: nxt = det ? S_REQ : S_IDLE;
      S_REQ:  nxt = !m68k_bg_n ? S_ACK : S_REQ;
      S_ACK:  nxt = S_CYC;
      S_CYC:  nxt = S_DTW;
      S_DTW: begin
        if (cnt == 4'd0 && !m68k_dtack_n) nxt = S_END;
`ifdef YM6045C_DTACK_TIMEOUT_EN
        else if (tcnt == 8'(TIMEOUT_CYCLES - 1)) begin
          nxt = S_END;
          tmo_nxt = 1'b1;
        end
`endif
      end
      S_END:  nxt = S_END == state ? S_REL : S_IDLE;
      S_REL:  nxt = z80_mreq_n ? S_IDLE : S_REL;
      default: nxt = S_IDLE;
    endcase
  end
  // state, latched access, counters and registered bus outputs decoded from the next state
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      state <= S_IDLE;
      wr_q <= 1'b1;
      lane <= 1'b0;
      cnt <= 4'd0;
      tcnt <= 8'd0;
      bank <= '0;
      m68k_rw <= 1'b1;
      m68k_a <= '0;
      z80_wait_n <= 1'b1;
      m68k_br_n <= 1'b1;
      m68k_bgack_n <= 1'b1;
      m68k_as_n <= 1'b1;
      m68k_uds_n <= 1'b1;
      m68k_lds_n <= 1'b1;
      m68k_addr_oe <= 1'b0;
      busy <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= nxt;
      wr_q <= z80_wr_n;
      if (bank_wr) bank <= {z80_d0, bank[BANK_WIDTH-1:1]};
      if (det) begin
        m68k_rw <= !z80_rd_n;
        m68k_a <= {bank, z80_a[14:1]};
        lane <= z80_a[0];
      end
      cnt <= state == S_CYC ? 4'(MIN_AS_CYCLES) : (state == S_DTW && cnt != 4'd0) ? cnt - 4'd1 : cnt;
      tcnt <= state == S_DTW ? tcnt + 8'd1 : 8'd0;
      z80_wait_n <= nxt == S_IDLE || nxt == S_REL;
      m68k_br_n <= nxt != S_REQ;
      m68k_bgack_n <= !own;
      m68k_addr_oe <= own;
      m68k_as_n <= !(nxt == S_CYC || nxt == S_DTW);
      m68k_uds_n <= !(strb && !lane);
      m68k_lds_n <= !(strb && lane);
      busy <= nxt != S_IDLE;
      timeout <= tmo_nxt;
    end
  end
endmodule

// File: tb/tb_ym6045c_z80_window_bridge.sv
// tb_ym6045c_z80_window_bridge: directed checks of bank loading, read/write window cycles, reset and optional timeout
module tb_ym6045c_z80_window_bridge;
  logic CLK = 1'b0, nRES = 1'b0;
  logic [15:0] z80_a = 16'h0;
  logic z80_mreq_n = 1'b1, z80_rd_n = 1'b1, z80_wr_n = 1'b1, z80_d0 = 1'b0;
  logic m68k_bg_n = 1'b1, m68k_dtack_n = 1'b1;
  logic z80_wait_n, m68k_br_n, m68k_bgack_n, m68k_as_n, m68k_uds_n, m68k_lds_n, m68k_rw, m68k_addr_oe, busy, timeout;
  logic [22:0] m68k_a;
  logic [8:0] bank;
  int checks = 0, errors = 0;
  int n;
  logic got;

  ym6045c_z80_window_bridge #(.BANK_WIDTH(9), .MIN_AS_CYCLES(2), .TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .nRES(nRES), .z80_a(z80_a), .z80_mreq_n(z80_mreq_n), .z80_rd_n(z80_rd_n),
    .z80_wr_n(z80_wr_n), .z80_d0(z80_d0), .z80_wait_n(z80_wait_n), .m68k_br_n(m68k_br_n),
    .m68k_bg_n(m68k_bg_n), .m68k_dtack_n(m68k_dtack_n), .m68k_bgack_n(m68k_bgack_n),
    .m68k_as_n(m68k_as_n), .m68k_uds_n(m68k_uds_n), .m68k_lds_n(m68k_lds_n), .m68k_rw(m68k_rw),
    .m68k_a(m68k_a), .m68k_addr_oe(m68k_addr_oe), .bank(bank), .busy(busy), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bwrite(input logic [15:0] addr, input logic d);
    z80_a = addr; z80_d0 = d; z80_mreq_n = 1'b0;
    step;
    z80_wr_n = 1'b0;
    step;
    z80_wr_n = 1'b1; z80_mreq_n = 1'b1;
    step;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wait"}, z80_wait_n, 1);
    chk({tag, "_br"}, m68k_br_n, 1);
    chk({tag, "_bgack"}, m68k_bgack_n, 1);
    chk({tag, "_as"}, m68k_as_n, 1);
    chk({tag, "_uds"}, m68k_uds_n, 1);
    chk({tag, "_lds"}, m68k_lds_n, 1);
    chk({tag, "_rw"}, m68k_rw, 1);
    chk({tag, "_oe"}, m68k_addr_oe, 0);
    chk({tag, "_a"}, m68k_a, 0);
    chk({tag, "_bank"}, bank, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tmo"}, timeout, 0);
  endtask

  initial begin
    repeat (2) step;
    chk_reset_outputs("rst");
    nRES = 1'b1;
    step;
    // bank loading, bit 0 first
    bwrite(16'h6000, 1'b1);
    chk("bank_first", bank, 9'h100);
    bwrite(16'h6000, 1'b0); bwrite(16'h6000, 1'b1); bwrite(16'h6000, 1'b0);
    bwrite(16'h6000, 1'b1); bwrite(16'h6000, 1'b0); bwrite(16'h6000, 1'b1);
    bwrite(16'h6000, 1'b0); bwrite(16'h6000, 1'b1);
    chk("bank_full", bank, 9'h155);
    bwrite(16'h6100, 1'b0);
    chk("bank_other_addr", bank, 9'h155);
    // window read at $8002
    z80_a = 16'h8002; z80_mreq_n = 1'b0; z80_rd_n = 1'b0;
    step;
    chk("rd_wait", z80_wait_n, 0);
    chk("rd_br", m68k_br_n, 0);
    chk("rd_busy", busy, 1);
    chk("rd_addr", m68k_a, 23'h554001);
    chk("rd_rw", m68k_rw, 1);
    step; step;
    chk("rd_br_held", m68k_br_n, 0);
    m68k_bg_n = 1'b0;
    step;
    chk("ack_bgack", m68k_bgack_n, 0);
    chk("ack_br", m68k_br_n, 1);
    chk("ack_oe", m68k_addr_oe, 1);
    chk("ack_as", m68k_as_n, 1);
    m68k_dtack_n = 1'b0;
    step;
    chk("cyc_as", m68k_as_n, 0);
    chk("cyc_uds", m68k_uds_n, 0);
    chk("cyc_lds", m68k_lds_n, 1);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      step;
      if (m68k_as_n) break;
      n++;
    end
    chk("rd_as_len", n, 4);
    chk("end_uds", m68k_uds_n, 1);
    chk("end_bgack", m68k_bgack_n, 0);
    chk("end_wait", z80_wait_n, 0);
    step;
    chk("rel_bgack", m68k_bgack_n, 1);
    chk("rel_oe", m68k_addr_oe, 0);
    chk("rel_wait", z80_wait_n, 1);
    chk("rel_busy", busy, 1);
    z80_mreq_n = 1'b1; z80_rd_n = 1'b1; m68k_bg_n = 1'b1; m68k_dtack_n = 1'b1;
    step;
    chk("rd_idle", busy, 0);
    // window write at $FFFF, grant and DTACK already low
    z80_a = 16'hFFFF; z80_mreq_n = 1'b0; z80_wr_n = 1'b0; m68k_bg_n = 1'b0; m68k_dtack_n = 1'b0;
    step;
    chk("wr_rw", m68k_rw, 0);
    chk("wr_addr", m68k_a, 23'h557FFF);
    step;
    step;
    chk("wr_cyc_as", m68k_as_n, 0);
    chk("wr_cyc_lds", m68k_lds_n, 1);
    step;
    chk("wr_dtw_lds", m68k_lds_n, 0);
    chk("wr_dtw_uds", m68k_uds_n, 1);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step;
      if (z80_wait_n) begin got = 1'b1; break; end
    end
    chk("wr_reach_rel", got, 1);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step;
      if (!m68k_as_n || !busy) n++;
    end
    chk("wr_single_cycle", n, 0);
    chk("bank_after_wr", bank, 9'h155);
    z80_mreq_n = 1'b1; z80_wr_n = 1'b1; m68k_bg_n = 1'b1; m68k_dtack_n = 1'b1;
    step;
    chk("wr_idle", busy, 0);
    // reset asserted while waiting for DTACK
    z80_a = 16'h8002; z80_mreq_n = 1'b0; z80_rd_n = 1'b0; m68k_bg_n = 1'b0;
    repeat (4) step;
    chk("dtw_as", m68k_as_n, 0);
    chk("dtw_tmo", timeout, 0);
    nRES = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    z80_mreq_n = 1'b1; z80_rd_n = 1'b1; m68k_bg_n = 1'b1;
    step;
    nRES = 1'b1;
    step;
    // bank write attempted while busy
    bwrite(16'h6000, 1'b1);
    chk("bank_one", bank, 9'h100);
    z80_a = 16'h8000; z80_mreq_n = 1'b0; z80_rd_n = 1'b0;
    step;
    chk("busy_req", busy, 1);
    z80_a = 16'h6000; z80_rd_n = 1'b1; z80_d0 = 1'b1;
    step;
    z80_wr_n = 1'b0;
    step; step;
    chk("bank_busy", bank, 9'h100);
    z80_wr_n = 1'b1; z80_mreq_n = 1'b1; m68k_bg_n = 1'b0; m68k_dtack_n = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step;
      if (!busy) begin got = 1'b1; break; end
    end
    chk("busy_done", got, 1);
    chk("bank_after_busy", bank, 9'h100);
    m68k_bg_n = 1'b1; m68k_dtack_n = 1'b1;
    step;
`ifdef YM6045C_DTACK_TIMEOUT_EN
    z80_a = 16'h8000; z80_mreq_n = 1'b0; z80_rd_n = 1'b0; m68k_bg_n = 1'b0;
    repeat (4) step;
    chk("to_dtw", m68k_as_n, 0);
    repeat (3) step;
    chk("to_early", timeout, 0);
    step;
    chk("to_pulse", timeout, 1);
    chk("to_end_as", m68k_as_n, 1);
    step;
    chk("to_clear", timeout, 0);
    chk("to_rel_wait", z80_wait_n, 1);
    z80_mreq_n = 1'b1; z80_rd_n = 1'b1; m68k_bg_n = 1'b1;
    step;
    chk("to_idle", busy, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ym6045c_z80_window_bridge.md
Name: ym6045c_z80_window_bridge

Overview:
Z80-to-68000 bank-window bridge of the arbiter. It holds the 9-bit Z80 bank register, written serially through $6000 bit 0. A Z80 access to $8000-$FFFF makes the bridge acquire the 68000 bus (BR/BG/BGACK), run one 68000 read/write cycle at {bank, A14:A0}, and stall the Z80 with WAIT until DTACK. It sits downstream of the Z80 address decode and upstream of the 68000 bus drivers and transceiver enables.

Parameters:
BANK_WIDTH, 9, bank register width (68000 A23..A15)
MIN_AS_CYCLES, 2, minimum CLK cycles AS stays low before DTACK is accepted (1..15)
TIMEOUT_CYCLES, 255, DTACK timeout in CLK cycles; used only with the optional feature (1..255)

Ports:
CLK  in  1  master clock; all inputs synchronous to it
nRES  in  1  asynchronous active-low reset
z80_a  in  16  Z80 address
z80_mreq_n  in  1  Z80 memory request
z80_rd_n  in  1  Z80 read strobe
z80_wr_n  in  1  Z80 write strobe
z80_d0  in  1  Z80 data bit 0, for bank writes
z80_wait_n  out  1  Z80 WAIT, low stalls the Z80
m68k_br_n  out  1  68000 bus request
m68k_bg_n  in  1  68000 bus grant
m68k_bgack_n  out  1  bus grant acknowledge
m68k_as_n  out  1  address strobe
m68k_uds_n  out  1  upper data strobe
m68k_lds_n  out  1  lower data strobe
m68k_rw  out  1  1 = read, 0 = write
m68k_a  out  23  68000 A23..A1
m68k_addr_oe  out  1  drive address and strobes onto the 68000 bus
bank  out  9  current bank register
busy  out  1  state != IDLE
timeout  out  1  one-cycle pulse on DTACK timeout (0 when the feature is absent)

Behaviour:
- Reset values:
  - bank = 0; state = IDLE; busy = 0; timeout = 0.
  - z80_wait_n = 1; m68k_br_n = 1; m68k_bgack_n = 1; m68k_as_n = 1; m68k_uds_n = 1; m68k_lds_n = 1.
  - m68k_rw = 1; m68k_addr_oe = 0; m68k_a = 0.
  - Reset mid-operation returns everything to these values immediately, with no bus handover.
- All outputs are registered. Each change appears the CLK edge after its cause.
- Bank write:
  - Trigger: mreq_n = 0, z80_a[15:8] = 8'h60, and a falling edge of z80_wr_n (previous sample 1, current 0).
  - Action: bank <= {z80_d0, bank[8:1]}.
  - One shift per strobe, accepted in IDLE only.
  - Nine writes load a full address, bit 0 first; bank then equals {last bit written, ..., first bit written}.
- Window access detect (IDLE only): mreq_n = 0, z80_a[15] = 1, and (rd_n = 0 or wr_n = 0).
  - Latch rw = rd_n ? 0 : 1 (the read/write direction).
  - Latch m68k_a = {bank, z80_a[14:1]}.
  - Latch lane from z80_a[0]: 0 selects UDS, 1 selects LDS.
- States:
  - IDLE: on detect -> REQ. z80_wait_n = 0 from the next edge; it stays low until REL.
  - REQ: m68k_br_n = 0. When bg_n == 0 -> ACK.
  - ACK: m68k_bgack_n = 0, m68k_br_n = 1, m68k_addr_oe = 1. Next cycle -> CYC.
  - CYC: as_n = 0 and the selected strobe = 0. For writes the strobe asserts one cycle after as_n. Load counter with MIN_AS_CYCLES -> DTW.
  - DTW: counter decrements to 0. Once it is 0 and dtack_n == 0 -> END.
  - END: as_n, uds_n, lds_n = 1. Next cycle -> REL.
  - REL: bgack_n = 1, m68k_addr_oe = 0, z80_wait_n = 1. Stay in REL until mreq_n == 1, then -> IDLE. One access yields exactly one 68000 cycle.
- Boundary rules:
  - DTACK low before the counter expires is ignored until it expires.
  - bg_n pulled high while in ACK..END has no effect; the cycle completes.
  - A Z80 strobe released mid-cycle cannot happen (WAIT is held) and is not checked.
  - mreq_n high in IDLE with a stale strobe: no detect.
  - Bank register: no wrap issue, pure shift.

Optional Feature:
Macro: YM6045C_DTACK_TIMEOUT_EN.
- Defined: an 8-bit counter runs in DTW. If dtack_n is still 1 after TIMEOUT_CYCLES cycles in DTW:
  - timeout pulses high for one cycle;
  - the state goes to END exactly as if DTACK had arrived.
- Undefined: the bridge waits forever in DTW, and timeout is tied to 0.

Test Plan:
1. Reset, then nine bank writes with d0 = 1,0,1,0,1,0,1,0,1 -> bank = 9'h155; writes with a16'h6100 address leave bank unchanged.
2. bank = 9'h155, Z80 read at 16'h8002; bg_n low 3 cycles after br_n, dtack_n low 1 cycle after as_n -> m68k_a = 23'h554001, uds_n = 0, lds_n = 1, rw = 1; as_n held for MIN_AS_CYCLES; wait_n returns to 1 in REL.
3. Z80 write at 16'hFFFF -> lds_n = 0, uds_n = 1, rw = 0; LDS asserts one cycle after AS; one bus cycle only while mreq_n is held 5 extra cycles.
4. nRES pulsed low in DTW -> all outputs return to reset values the same cycle; bank = 0.
5. With YM6045C_DTACK_TIMEOUT_EN and TIMEOUT_CYCLES = 4, dtack_n held 1 -> timeout pulse 4 cycles after DTW entry, then END/REL/IDLE.
6. Bank write attempted while busy (forced) -> bank unchanged.
